// File: rtl/cmdspi_regbank.sv
// Register bank behind the SPI command slave: control/pulse outputs, sticky status with IRQ, timer, push-only FIFO.
// Optional TIMER at 0x06 is built only when CMDSPI_REGBANK_TIMER_EN is defined.
module cmdspi_regbank #(
  parameter logic [31:0] ID_VALUE   = 32'h1CE4_0001,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [6:0]  addr,
  input  logic [31:0] wdat,
  output logic [31:0] rdat,
  output logic [31:0] ctrl_out,
  output logic [31:0] pulse_out,
  input  logic [15:0] status_in,
  output logic        irq,
  output logic [31:0] fifo_data,
  output logic        fifo_valid,
  input  logic        fifo_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  localparam logic [6:0] A_ID        = 7'h00;
  localparam logic [6:0] A_SCRATCH   = 7'h01;
  localparam logic [6:0] A_CTRL      = 7'h02;
  localparam logic [6:0] A_STATUS    = 7'h03;
  localparam logic [6:0] A_IRQ_MASK  = 7'h04;
  localparam logic [6:0] A_PULSE     = 7'h05;
  localparam logic [6:0] A_TIMER     = 7'h06;
  localparam logic [6:0] A_FIFO_DATA = 7'h07;
  localparam logic [6:0] A_FIFO_STAT = 7'h08;

  logic [31:0] scratch;
  logic [15:0] irq_mask;
  logic [15:0] sync1, sync2, sync_d, sticky;
  logic [15:0] rise;
  logic [31:0] timer_rd;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic [8:0]    level9;
  logic          overflow;
  logic          fifo_full, fifo_empty;
  logic          push, pop, push_ok, ovf_set;

  logic wr_scratch, wr_ctrl, wr_status, wr_mask, wr_pulse, wr_fifo_stat;

  assign wr_scratch   = we && (addr == A_SCRATCH);
  assign wr_ctrl      = we && (addr == A_CTRL);
  assign wr_status    = we && (addr == A_STATUS);
  assign wr_mask      = we && (addr == A_IRQ_MASK);
  assign wr_pulse     = we && (addr == A_PULSE);
  assign wr_fifo_stat = we && (addr == A_FIFO_STAT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch   <= '0;
      ctrl_out  <= '0;
      irq_mask  <= '0;
      pulse_out <= '0;
    end else begin
      if (wr_scratch) scratch  <= wdat;
      if (wr_ctrl)    ctrl_out <= wdat;
      if (wr_mask)    irq_mask <= wdat[15:0];
      pulse_out <= wr_pulse ? wdat : '0;
    end
  end

  // Two synchroniser stages, then one edge-detect flop; a rise lands in sticky on the third edge.
  assign rise = sync2 & ~sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      sync_d <= '0;
      sticky <= '0;
      irq    <= 1'b0;
    end else begin
      sync1  <= status_in;
      sync2  <= sync1;
      sync_d <= sync2;
      sticky <= (sticky & ~(wr_status ? wdat[15:0] : 16'h0000)) | rise;
      irq    <= |(sticky & irq_mask);
    end
  end

`ifdef CMDSPI_REGBANK_TIMER_EN
  logic [31:0] timer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (we && (addr == A_TIMER)) begin
      timer <= wdat;
    end else begin
      timer <= timer + 32'd1;
    end
  end

  assign timer_rd = timer;
`else
  assign timer_rd = '0;
`endif

  assign fifo_full  = (level == LW'(FIFO_DEPTH));
  assign fifo_empty = (level == '0);
  assign fifo_valid = !fifo_empty;
  assign pop        = fifo_valid && fifo_ready;
  assign push       = we && (addr == A_FIFO_DATA);
  // A full FIFO still takes the word when the consumer frees a slot on the same edge.
  assign push_ok    = push && (!fifo_full || pop);
  assign ovf_set    = push && fifo_full && !pop;
  assign level9     = 9'(level);

  // NOTE: the storage array has no reset; validity is tracked by the pointers and level alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdat;
  end

  assign fifo_data = fifo_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      overflow <= ovf_set | (overflow & ~(wr_fifo_stat & wdat[31]));
    end
  end

  // NOTE: every path assigns rdat through the default first, so no latch is inferred.
  always_comb begin
    rdat = '0;
    case (addr)
      A_ID:        rdat = ID_VALUE;
      A_SCRATCH:   rdat = scratch;
      A_CTRL:      rdat = ctrl_out;
      A_STATUS:    rdat = {sync2, sticky};
      A_IRQ_MASK:  rdat = {16'h0000, irq_mask};
      A_TIMER:     rdat = timer_rd;
      A_FIFO_DATA: rdat = {24'h000000, level9[7:0]};
      A_FIFO_STAT: rdat = {overflow, fifo_empty, fifo_full, 20'h00000, level9};
      default:     rdat = '0;
    endcase
  end

endmodule

// File: tb/tb_cmdspi_regbank.sv
// Self-checking bench for cmdspi_regbank: directed register/FIFO/status scenarios plus a randomized
// phase checked against a queue-based reference model.
module tb_cmdspi_regbank;

  localparam logic [31:0] ID_VALUE   = 32'h1CE4_0001;
  localparam int          FIFO_DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [6:0]  addr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic [31:0] ctrl_out;
  logic [31:0] pulse_out;
  logic [15:0] status_in;
  logic        irq;
  logic [31:0] fifo_data;
  logic        fifo_valid;
  logic        fifo_ready;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_ctrl, m_scratch, m_mask, m_pulse;
  logic        m_ovf;
  logic [31:0] m_q[$];

  cmdspi_regbank #(.ID_VALUE(ID_VALUE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .wdat(wdat), .rdat(rdat),
    .ctrl_out(ctrl_out), .pulse_out(pulse_out), .status_in(status_in), .irq(irq),
    .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_ready(fifo_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdat = d;
    tick();
    we = 1'b0;
  endtask

  task automatic check_rd(input string tag, input logic [6:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdat, exp);
  endtask

  function automatic logic [31:0] fifo_stat_model();
    int n;
    n = m_q.size();
    return (m_ovf ? 32'h8000_0000 : 32'h0) | ((n == 0) ? 32'h4000_0000 : 32'h0) |
           ((n == FIFO_DEPTH) ? 32'h2000_0000 : 32'h0) | 32'(n);
  endfunction

  initial begin
    rst_n = 1'b0; we = 1'b0; addr = '0; wdat = '0; status_in = '0; fifo_ready = 1'b0;
    repeat (3) tick();
    check("reset_irq", {31'b0, irq}, 32'h0);
    check("reset_pulse", pulse_out, 32'h0);
    rst_n = 1'b1;
    tick();

    // 1: reset state
    check_rd("id", 7'h00, ID_VALUE);
    check_rd("ctrl_rd_reset", 7'h02, 32'h0);
    check("ctrl_out_reset", ctrl_out, 32'h0);
    check("irq_reset", {31'b0, irq}, 32'h0);
    check("fifo_valid_reset", {31'b0, fifo_valid}, 32'h0);
    check_rd("fifo_stat_reset", 7'h08, 32'h4000_0000);
    check_rd("unmapped_rd", 7'h7F, 32'h0);

    // 2: CTRL hold and PULSE one-shot
    wr(7'h02, 32'hDEAD_BEEF);
    check("ctrl_out", ctrl_out, 32'hDEAD_BEEF);
    wr(7'h05, 32'h0000_0081);
    check("pulse_on", pulse_out, 32'h0000_0081);
    check_rd("pulse_reads0", 7'h05, 32'h0);
    tick();
    check("pulse_off", pulse_out, 32'h0);
    check("ctrl_held", ctrl_out, 32'hDEAD_BEEF);
    wr(7'h09, 32'h1234_5678);
    check_rd("unmapped_write_ignored", 7'h09, 32'h0);

    // 3: status synchroniser, sticky flag, IRQ
    wr(7'h04, 32'hFFFF_0001);
    check_rd("mask_rd", 7'h04, 32'h0000_0001);
    status_in = 16'h0001;
    tick(); tick();
    check_rd("status_after2", 7'h03, 32'h0001_0000);
    tick();
    check_rd("status_after3", 7'h03, 32'h0001_0001);
    check("irq_lags", {31'b0, irq}, 32'h0);
    tick();
    check("irq_set", {31'b0, irq}, 32'h1);
    wr(7'h03, 32'h0000_0001);
    check_rd("status_w1c", 7'h03, 32'h0001_0000);
    tick();
    check("irq_clear", {31'b0, irq}, 32'h0);
    status_in = 16'h0000;
    repeat (3) tick();
    status_in = 16'h0001;
    tick(); tick();
    wr(7'h03, 32'h0000_0001);
    check_rd("status_set_wins", 7'h03, 32'h0001_0001);
    status_in = 16'h0000;
    repeat (4) tick();
    wr(7'h03, 32'h0000_FFFF);
    tick();
    check_rd("status_cleared", 7'h03, 32'h0);
    check("irq_idle", {31'b0, irq}, 32'h0);

    // 4: overflow on a full FIFO, then in-order drain
    fifo_ready = 1'b0;
    for (int i = 0; i < 17; i++) wr(7'h07, 32'(i));
    check_rd("fifo_stat_ovf", 7'h08, 32'hA000_0010);
    check_rd("fifo_level_rd", 7'h07, 32'h0000_0010);
    check("fifo_head0", fifo_data, 32'h0);
    wr(7'h08, 32'h8000_0000);
    check_rd("ovf_w1c", 7'h08, 32'h2000_0010);
    fifo_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_valid", {31'b0, fifo_valid}, 32'h1);
      check("drain_data", fifo_data, 32'(i));
      tick();
    end
    fifo_ready = 1'b0;
    check("drained_valid", {31'b0, fifo_valid}, 32'h0);
    check_rd("drained_stat", 7'h08, 32'h4000_0000);

    // 5: push and pop on the same edge while full
    for (int i = 0; i < 16; i++) wr(7'h07, 32'(200 + i));
    check_rd("full_stat", 7'h08, 32'h2000_0010);
    fifo_ready = 1'b1;
    wr(7'h07, 32'd999);
    fifo_ready = 1'b0;
    check_rd("full_pushpop_stat", 7'h08, 32'h2000_0010);
    fifo_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      check("pp_data", fifo_data, 32'(201 + i));
      tick();
    end
    check("pp_last", fifo_data, 32'd999);
    tick();
    fifo_ready = 1'b0;
    check("pp_empty", {31'b0, fifo_valid}, 32'h0);
    tick();
    fifo_ready = 1'b1;
    tick();
    fifo_ready = 1'b0;
    check_rd("pop_empty_ignored", 7'h08, 32'h4000_0000);

    // 6: timer
`ifdef CMDSPI_REGBANK_TIMER_EN
    wr(7'h06, 32'hFFFF_FFFE);
    tick();
    check_rd("timer_ff", 7'h06, 32'hFFFF_FFFF);
    tick();
    check_rd("timer_wrap", 7'h06, 32'h0);
`else
    wr(7'h06, 32'hFFFF_FFFE);
    check_rd("timer_absent", 7'h06, 32'h0);
    tick();
    check_rd("timer_absent2", 7'h06, 32'h0);
`endif

    // Randomized phase against the reference model
    m_ctrl = 32'hDEAD_BEEF; m_scratch = '0; m_mask = 32'h1; m_ovf = 1'b0; m_pulse = '0;
    m_q.delete();
    for (int n = 0; n < 300; n++) begin
      logic [6:0]  a;
      logic [31:0] d;
      logic        do_we, rdy, mpop, mpush, ovf_s, ovf_c;
      a = ($urandom_range(0, 2) == 0) ? 7'h07 : 7'($urandom_range(0, 9));
      if (a == 7'h06) a = 7'h01;
      d = $urandom;
      if ($urandom_range(0, 1) == 1) d[31] = 1'b0;
      do_we = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      mpop  = rdy && (m_q.size() > 0);
      mpush = do_we && (a == 7'h07);
      ovf_s = mpush && (m_q.size() == FIFO_DEPTH) && !mpop;
      ovf_c = do_we && (a == 7'h08) && d[31];
      we = do_we; addr = a; wdat = d; fifo_ready = rdy;
      tick();
      we = 1'b0; fifo_ready = 1'b0;
      if (do_we && a == 7'h01) m_scratch = d;
      if (do_we && a == 7'h02) m_ctrl = d;
      if (do_we && a == 7'h04) m_mask = d & 32'h0000_FFFF;
      m_pulse = (do_we && a == 7'h05) ? d : 32'h0;
      if (mpop) void'(m_q.pop_front());
      if (mpush && !ovf_s) m_q.push_back(d);
      m_ovf = ovf_s | (m_ovf & !ovf_c);
      check("rnd_ctrl", ctrl_out, m_ctrl);
      check("rnd_pulse", pulse_out, m_pulse);
      check("rnd_valid", {31'b0, fifo_valid}, {31'b0, m_q.size() != 0});
      check("rnd_head", fifo_data, (m_q.size() != 0) ? m_q[0] : 32'h0);
      check_rd("rnd_fifo_stat", 7'h08, fifo_stat_model());
      check_rd("rnd_scratch", 7'h01, m_scratch);
      check_rd("rnd_mask", 7'h04, m_mask);
      check("rnd_irq", {31'b0, irq}, 32'h0);
    end

    // Reset asserted mid-operation
    wr(7'h04, 32'h0000_0001);
    status_in = 16'h0001;
    repeat (5) tick();
    check("pre_reset_irq", {31'b0, irq}, 32'h1);
    wr(7'h07, 32'h0000_0055);
    wr(7'h05, 32'h0000_000F);
    check("pre_reset_pulse", pulse_out, 32'h0000_000F);
    rst_n = 1'b0;
    #1;
    check("rst_pulse_lost", pulse_out, 32'h0);
    check("rst_irq_drop", {31'b0, irq}, 32'h0);
    check("rst_fifo_empty", {31'b0, fifo_valid}, 32'h0);
    check("rst_ctrl", ctrl_out, 32'h0);
    check_rd("rst_status", 7'h03, 32'h0);
    check_rd("rst_id", 7'h00, ID_VALUE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
